// File: rtl/modexp_param.sv
// Modular exponentiator: left-to-right square-and-multiply over a bit-serial interleaved modular multiplier.
// Optional build macro MODEXP_LEADING_ZERO_SKIP_EN starts the scan at the highest set exponent bit.
//
// state | meaning
// IDLE  | waiting for go
// LOAD  | capture operands, check legality, pick start bit
// SQR   | R = R*R mod M, one multiplier bit per cycle
// MUL   | R = R*A mod M, one multiplier bit per cycle
// FIN   | present result, hold done until go drops
module modexp_param #(
  parameter int WIDTH = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] message,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] cypher,
  output logic             done,
  output logic             busy,
  output logic             error
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, LOAD, SQR, MUL, FIN} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] a, e, m, r, mb;
  logic [WIDTH+1:0] p, p_next;
  logic [IW-1:0]    cnt, idx, start_idx;
  logic             err, bad, has_one, last;

  assign bad  = (modulus < WIDTH'(2)) || (message >= modulus);
  assign last = (cnt == '0);
  assign busy = (state == LOAD) || (state == SQR) || (state == MUL);

`ifdef MODEXP_LEADING_ZERO_SKIP_EN
  always_comb begin
    start_idx = '0;
    has_one   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (exponent[i]) begin
        start_idx = IW'(i);
        has_one   = 1'b1;
      end
    end
  end
`else
  assign start_idx = IW'(WIDTH - 1);
  assign has_one   = 1'b1;
`endif

  // One interleaved step: double, reduce, conditionally add addend, reduce.
  always_comb begin
    logic [WIDTH+1:0] mext, aext, p2, p3;
    mext = {2'b00, m};
    aext = {2'b00, (state == MUL) ? a : r};
    p2 = p << 1;
    if (p2 >= mext) p2 = p2 - mext;
    p3 = p2 + (mb[WIDTH-1] ? aext : '0);
    if (p3 >= mext) p3 = p3 - mext;
    p_next = p3;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (go) state_next = LOAD;
      LOAD: begin
        if (bad || !has_one) state_next = FIN;
        else                 state_next = SQR;
      end
      SQR: if (last) begin
        if (e[idx])            state_next = MUL;
        else if (idx == '0)    state_next = FIN;
        else                   state_next = SQR;
      end
      MUL: if (last) state_next = (idx == '0) ? FIN : SQR;
      FIN: if (done && !go) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a <= '0; e <= '0; m <= '0; r <= '0; mb <= '0; p <= '0;
      cnt <= '0; idx <= '0; err <= 1'b0;
      cypher <= '0; done <= 1'b0; error <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          a   <= message;
          e   <= exponent;
          m   <= modulus;
          err <= bad;
          r   <= WIDTH'(1);
          mb  <= WIDTH'(1);
          p   <= '0;
          cnt <= IW'(WIDTH - 1);
          idx <= start_idx;
        end
        SQR, MUL: begin
          if (last) begin
            r   <= p_next[WIDTH-1:0];
            mb  <= p_next[WIDTH-1:0];
            p   <= '0;
            cnt <= IW'(WIDTH - 1);
            if (state_next == SQR) idx <= idx - 1'b1;
          end else begin
            p   <= p_next;
            mb  <= mb << 1;
            cnt <= cnt - 1'b1;
          end
        end
        FIN: begin
          if (!done) begin
            done   <= 1'b1;
            error  <= err;
            cypher <= err ? '0 : r;
          end else if (!go) begin
            done  <= 1'b0;
            error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_modexp_param.sv
// Bench for modexp_param at WIDTH=8: directed vectors, reset abort, and random operands vs an arithmetic model.
module tb_modexp_param;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         reset, go;
  logic [W-1:0] message, exponent, modulus, cypher;
  logic         done, busy, error;
  int           tests = 0;
  int           fails = 0;

  modexp_param #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .go(go), .message(message), .exponent(exponent),
    .modulus(modulus), .cypher(cypher), .done(done), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int unsigned mexp(input int unsigned b, input int unsigned ex, input int unsigned md);
    longint unsigned res = 1 % md;
    longint unsigned x = b % md;
    int unsigned ee = ex;
    while (ee != 0) begin
      if (ee[0]) res = (res * x) % md;
      x = (x * x) % md;
      ee = ee >> 1;
    end
    return int'(res);
  endfunction

  function automatic int latency(input int unsigned ex, input bit bad);
    int k = W;
    if (bad) return 2;
`ifdef MODEXP_LEADING_ZERO_SKIP_EN
    k = 0;
    for (int i = 0; i < W; i++) if (ex[i]) k = i + 1;
`endif
    return 2 + (k + $countones(ex[W-1:0])) * W;
  endfunction

  task automatic run(input int unsigned b, input int unsigned ex, input int unsigned md, input bit toggle);
    bit bad  = (md < 2) || (b >= md);
    int expc = bad ? 0 : mexp(b, ex, md);
    int expn = latency(ex, bad);
    int n    = 0;
    bit got  = 0;
    @(negedge clk);
    message = W'(b); exponent = W'(ex); modulus = W'(md); go = 1'b1;
    while (!got && n < 400) begin
      @(posedge clk); #1; n++;
      if (n == 3 && expn > 3) chk("busy_mid", busy, 1);
      if (toggle && n == 5) begin
        message = W'($urandom); exponent = W'($urandom); modulus = W'($urandom);
      end
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
    chk("latency", n - 1, expn);
    chk("cypher", cypher, expc);
    chk("error", error, bad);
    chk("busy_fin", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", done, 1);
    chk("cypher_held", cypher, expc);
    @(negedge clk); go = 1'b0;
    @(posedge clk); #1;
    chk("done_drop", done, 0);
    chk("cypher_kept", cypher, expc);
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; message = '0; exponent = '0; modulus = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cypher", cypher, 0);
    chk("rst_error", error, 0);
    @(negedge clk); reset = 1'b0;

    run(8, 13, 77, 1'b0);
    chk("vec_8_13_77", cypher, 50);
    run(50, 37, 77, 1'b0);
    chk("vec_50_37_77", cypher, 8);
    run(5, 3, 1, 1'b0);
    run(80, 5, 77, 1'b0);
    run(5, 0, 77, 1'b0);
    run(0, 9, 77, 1'b0);
    run(76, 255, 77, 1'b1);

    // Abort a run 20 cycles in, go still high.
    @(negedge clk);
    message = 8'd8; exponent = 8'd13; modulus = 8'd77; go = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cypher", cypher, 0);
    chk("abort_error", error, 0);
    @(negedge clk); reset = 1'b0; go = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done, 0);
    run(8, 13, 77, 1'b0);

    for (int t = 0; t < 25; t++) begin
      int unsigned md = $urandom_range(3, 255) | 1;
      run($urandom % md, $urandom_range(0, 255), md, t[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
